// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: opcodes, FSM states and helpers shared by the accumulator CPU core
package acc_cpu_pkg;
  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_AND   = 3'd4;
  localparam logic [2:0] OP_JMP   = 3'd5;
  localparam logic [2:0] OP_JZ    = 3'd6;
  localparam logic [2:0] OP_SYS   = 3'd7;
  // operand bit that selects HALT (1) versus OUT (0) under OP_SYS
  localparam int SYS_HALT_BIT = 0;
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_OUT_WAIT, S_HALT} state_t;
  function automatic logic writes_acc(logic [2:0] op);
    return op inside {OP_LOAD, OP_ADD, OP_SUB, OP_AND};
  endfunction
endpackage

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu: combinational accumulator ALU, result wraps modulo 2**DATA_W
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result
);
  // non-accumulator opcodes pass the accumulator through unchanged
  always_comb
    result = op == OP_LOAD ? b :
             op == OP_ADD  ? a + b :
             op == OP_SUB  ? a - b :
             op == OP_AND  ? a & b : a;
endmodule

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: parametrised accumulator CPU with zero branch, halt and valid/ready output
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [ADDR_W+2:0] instr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] acc,
  output logic              halted
);
  localparam int IW = 3 + ADDR_W;
  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [IW-1:0]     ir;
  logic [DATA_W-1:0] mem [0:2**ADDR_W-1];
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] alu_result;
  logic              branch;
  assign opcode     = ir[IW-1 -: 3];
  assign operand    = ir[ADDR_W-1:0];
  assign pc_next    = pc + ADDR_W'(1);
  assign branch     = opcode == OP_JMP || (opcode == OP_JZ && acc == '0);
  assign instr_addr = pc;
  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (acc),
    .b      (mem[operand]),
    .op     (opcode),
    .result (alu_result)
  );
  // data memory: unreset, written only by STORE at the EXEC edge
  always_ff @(posedge clk)
    if (reset && state == S_EXEC && opcode == OP_STORE) mem[operand] <= acc;
  // fetch/execute sequencer; OUT parks in OUT_WAIT until the consumer takes the word
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= '0;
      acc       <= '0;
      ir        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          ir    <= instr_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (writes_acc(opcode)) acc <= alu_result;
          if (opcode != OP_SYS) begin
            pc    <= branch ? operand : pc_next;
            state <= S_FETCH;
          end else if (operand[SYS_HALT_BIT]) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state     <= S_OUT_WAIT;
            out_valid <= 1'b1;
            out_data  <= acc;
          end
        end
        S_OUT_WAIT:
          if (out_ready) begin
            out_valid <= 1'b0;
            pc        <= pc_next;
            state     <= S_FETCH;
          end
        S_HALT: ;
      endcase
    end
  end
endmodule

// File: doc/acc_cpu_core.md
# acc_cpu_core

Parametrised accumulator CPU core: the next generation of the 8-bit/5-bit-PC accumulator machine, generalised in data width and address width. It adds a zero-flag conditional branch, a halt state, and a valid/ready output port that stalls the core under backpressure, replacing the fire-and-forget UART send. It fetches from an external combinational instruction ROM, owns its data memory, and sits between the program ROM and the serial output block in the top level.

## Interface
- DATA_W, 8, accumulator / data-memory word width (>=4)
- ADDR_W, 5, PC and data-memory address width; data memory depth 2**ADDR_W; instruction width IW = 3+ADDR_W
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
- instr_addr  out  ADDR_W  current PC; ROM returns instr_data combinationally
- instr_data  in  IW  [IW-1:IW-3] opcode, [ADDR_W-1:0] operand
- out_valid  out  1  output word available
- out_ready  in  1  consumer accepts when out_valid&&out_ready
- out_data  out  DATA_W  accumulator snapshot, stable while out_valid
- acc  out  DATA_W  accumulator (debug)
- halted  out  1  core in HALT state

## Operation
- Opcodes (a = operand): 000 LOAD acc=mem[a]; 001 STORE mem[a]=acc; 010 ADD acc+=mem[a]; 011 SUB acc-=mem[a]; 100 AND acc&=mem[a]; 101 JMP pc=a; 110 JZ pc=a if acc==0 else pc+1; 111 with a[0]=0 OUT, a[0]=1 HALT.
- States: FETCH -> EXEC -> FETCH; EXEC(OUT) -> OUT_WAIT; OUT_WAIT -> FETCH on handshake; EXEC(HALT) -> HALT (absorbing until reset).
- FETCH: IR <= instr_data. EXEC: perform opcode, update pc, write acc/mem.
- Arithmetic modulo 2**DATA_W; no carry/overflow flag. Zero test uses acc value at EXEC.
- pc+1 wraps from 2**ADDR_W-1 to 0; no halt on wrap.
- OUT: out_data captured from acc on entry to OUT_WAIT; pc advances only after handshake.
- STORE write and any acc write occur at the EXEC clock edge; a LOAD in the next instruction sees the stored value.
- Data memory not reset (contents X until written); verification must write before read.

## Timing
- Reset (reset==0 at edge): pc=0, acc=0, IR=0, state=FETCH, out_valid=0, out_data=0, halted=0. Reset dominates every state including OUT_WAIT mid-handshake and HALT.
- Non-OUT instruction: 2 cycles (FETCH, EXEC). JMP/JZ target fetched in the following FETCH.
- OUT: out_valid rises the cycle after EXEC; with out_ready held 1, the instruction takes 3 cycles; each cycle of out_ready=0 adds one.
- out_valid never drops without a handshake; out_data constant while out_valid=1.
- halted=1 from the cycle after EXEC of HALT; pc frozen at the HALT address; out_valid=0.
- instr_addr changes only at EXEC/OUT_WAIT exit edges; stable throughout FETCH.

## Structure
- Package acc_cpu_pkg: opcode constants (OP_LOAD..OP_SYS), state enum (S_FETCH, S_EXEC, S_OUT_WAIT, S_HALT), OUT/HALT sub-code bit index.
- Sub-module acc_cpu_alu: combinational, ports a, b, op -> result, DATA_W-parametrised; the core instantiates it once.
- Data memory is an inferred register array inside the core (asynchronous read, synchronous write).

## Test plan
- Reset: hold reset=0 3 cycles mid-program -> pc=0, acc=0, out_valid=0, halted=0 on the cycle after release.
- Arithmetic: program LOAD m0(=200), ADD m1(=100), OUT with DATA_W=8 -> out_data=44 (wrap); SUB m1 from 44 -> 200.
- Branch: acc=0, JZ 7 -> next instr_addr=7; acc=5, JZ 7 -> instr_addr=pc+1; JMP from address 31 (ADDR_W=5) wraps correctly; sequential pc at 31 -> 0.
- Backpressure: OUT with out_ready=0 for 5 cycles -> out_valid high and out_data stable 5 cycles, pc unchanged; handshake on cycle 6 -> FETCH next instruction.
- HALT: HALT at address 9 -> halted=1, instr_addr=9 indefinitely, no further STOREs; reset=0 -> restart at 0.
- Parametrisation: DATA_W=16, ADDR_W=8: STORE 0xFFFF to mem[255], LOAD, ADD mem[255] -> acc=0xFFFE.
